// File: rtl/rv32_pkg.sv
// rv32_pkg: encodings shared between the control unit and the load/store unit.
// Holds func3 load/store encodings, access-size codes, the LSU state enum and
// the opcode constants the decoder already uses.
package rv32_pkg;

    // Major opcodes shared with the control unit
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // func3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size carried in func3[1:0]; func3[2] selects zero-extension
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// lsu_if: data-memory port of the load/store unit (single outstanding req/ack).
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : LSU -> memory
//   mem_ack/mem_rdata                         : memory -> LSU (rdata valid with ack)
interface lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
//   func3, addr_lo, wdata -> be_c, wdata_c   (byte enables, replicated store data)
//   func3, addr_lo, mem_rdata -> rdata_c     (extracted, sign/zero-extended load data)
// Halfword/word accesses ignore the sub-unit address bits, i.e. they round
// down to the containing aligned halfword/word.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        rdata_c = mem_rdata;
        lane_b  = mem_rdata[{addr_lo, 3'b000} +: 8];
        lane_h  = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
        case (func3[1:0])
            SZ_B: begin
                be_c    = 4'b0001 << addr_lo;
                wdata_c = {4{wdata[7:0]}};
                rdata_c = func3[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            SZ_H: begin
                be_c    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_c = {2{wdata[15:0]}};
                rdata_c = func3[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit. Accepts a MemRead/MemWrite request in IDLE, performs one
// req/ack access to data memory and returns extended load data with a one-cycle
// done pulse; busy is high whenever the unit is not IDLE.
//   clk, rst (sync, active-high)
//   valid, MemRead, MemWrite, func3, addr, wdata : request from the core
//   busy, done, rdata, err                        : status/result to the core
//   mem (lsu_if.master)                           : data-memory port
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses illegal
// (err, no memory access); otherwise they round down to the aligned unit.
module lsu
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    lsu_if.master       mem
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    lsu_state_e       state_q, state_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       alo_q, alo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;

    logic        legal_c;
    logic [2:0]  al_f3_c;
    logic [1:0]  al_alo_c;
    logic [3:0]  al_be_c;
    logic [31:0] al_wdata_c, al_rdata_c;

    // In IDLE the aligner steers the incoming request; in REQ it extracts from
    // the captured func3/address.
    assign al_f3_c  = (state_q == S_IDLE) ? func3      : f3_q;
    assign al_alo_c = (state_q == S_IDLE) ? addr[1:0]  : alo_q;

    lsu_align u_align (
        .func3     (al_f3_c),
        .addr_lo   (al_alo_c),
        .wdata     (wdata),
        .mem_rdata (mem.mem_rdata),
        .be_c      (al_be_c),
        .wdata_c   (al_wdata_c),
        .rdata_c   (al_rdata_c)
    );

    // Request legality
    always_comb begin
        legal_c = 1'b1;
        if (MemRead && MemWrite) begin
            legal_c = 1'b0;
        end else if (MemRead) begin
            legal_c = (func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else begin
            legal_c = (func3 inside {F3_B, F3_H, F3_W});
        end
        if (MISALIGN_TRAP) begin
            if ((func3[1:0] == SZ_H) && addr[0])
                legal_c = 1'b0;
            if ((func3[1:0] == F3_W[1:0]) && (addr[1:0] != 2'b00))
                legal_c = 1'b0;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        alo_d       = alo_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (valid && (MemRead || MemWrite)) begin
                    f3_d  = func3;
                    alo_d = addr[1:0];
                    cnt_d = '0;
                    if (legal_c) begin
                        state_d     = S_REQ;
                        mem_we_d    = MemWrite;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = al_be_c;
                        mem_wdata_d = al_wdata_c;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            S_REQ: begin
                // ack in the final counted cycle still completes normally
                if (mem.mem_ack) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    rdata_d = mem_we_q ? 32'd0 : al_rdata_c;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        mem_req_d = (state_d == S_REQ);
        if (state_d != S_REQ)
            mem_we_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            f3_q        <= '0;
            alo_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            alo_q       <= alo_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu (TIMEOUT=4). Directed vector table,
// hand-written reset/no-op/back-to-back sequences, and random requests checked
// against a behavioural model of the access rules.
module tb_lsu;

    localparam int unsigned TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, valid, MemRead, MemWrite;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata;

    lsu_if mem_bus ();

    lsu #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .func3    (func3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lat;
        int          req;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wd;
    } exp_t;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          dly;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic        done_seen;
        int          lat;
        int          req;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        unstable;
        logic        busy_bad;
        logic        idle_after;
    } res_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(int lat, int req, logic e, logic [31:0] rd,
                                     logic [31:0] ad, logic [3:0] be, logic we,
                                     logic [31:0] wd, logic cw);
        exp_t x;
        x.lat = lat; x.req = req; x.err = e; x.rdata = rd; x.addr = ad;
        x.be = be; x.we = we; x.wdata = wd; x.chk_wd = cw;
        return x;
    endfunction

    function automatic vec_t mk_vec(logic mr, logic mw, logic [2:0] f3, logic [31:0] a,
                                     logic [31:0] wd, logic [31:0] mrd, int dly, exp_t e);
        vec_t v;
        v.mr = mr; v.mw = mw; v.f3 = f3; v.a = a; v.wd = wd; v.mrd = mrd; v.dly = dly; v.e = e;
        return v;
    endfunction

    // Reference model: access rules expressed with plain arithmetic
    function automatic exp_t model(logic mr, logic mw, logic [2:0] f3, logic [31:0] a,
                                    logic [31:0] wd, logic [31:0] mrd, int dly);
        exp_t        x;
        int          nb, off;
        logic [31:0] mask, v;
        logic        legal;
        nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (mr && mw)  legal = 1'b0;
        else if (mr)   legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else           legal = (f3 inside {3'b000, 3'b001, 3'b010});
        if (TRAP && ((int'(a[1:0]) % nb) != 0)) legal = 1'b0;
        off      = (int'(a[1:0]) / nb) * nb;
        x.err    = !legal;
        x.rdata  = 32'd0;
        x.addr   = a & 32'hFFFF_FFFC;
        x.be     = 4'(((32'd1 << nb) - 32'd1) << off);
        x.we     = mw;
        x.wdata  = (nb == 1) ? (wd & 32'h0000_00FF) * 32'h0101_0101 :
                   (nb == 2) ? (wd & 32'h0000_FFFF) * 32'h0001_0001 : wd;
        x.chk_wd = mw;
        if (!legal) begin
            x.lat = 1; x.req = 0;
        end else if (dly >= int'(TO)) begin
            x.lat = int'(TO) + 1; x.req = int'(TO); x.err = 1'b1;
        end else begin
            x.lat = dly + 2; x.req = dly + 1;
            if (mr) begin
                mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 64'd1);
                v = (mrd >> (8 * off)) & mask;
                if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
                x.rdata = v;
            end
        end
        return x;
    endfunction

    // Issue one request and act as memory; ack after dly extra REQ cycles
    task automatic run_op(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] mrd, input int dly, output res_t r);
        r.done_seen = 0; r.lat = 0; r.req = 0; r.err = 0; r.rdata = 0; r.addr = 0;
        r.be = 0; r.we = 0; r.wdata = 0; r.unstable = 0; r.busy_bad = 0; r.idle_after = 0;
        @(negedge clk);
        valid = 1'b1; MemRead = mr; MemWrite = mw; func3 = f3; addr = a; wdata = wd;
        mem_bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        addr = $urandom; wdata = $urandom; func3 = 3'($urandom);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = $urandom;
            if (done) begin
                r.done_seen = 1'b1; r.lat = k; r.err = err; r.rdata = rdata;
                break;
            end
            if (mem_bus.mem_req) begin
                if (r.req == 0) begin
                    r.addr = mem_bus.mem_addr; r.be = mem_bus.mem_be;
                    r.we = mem_bus.mem_we; r.wdata = mem_bus.mem_wdata;
                end else if (r.addr !== mem_bus.mem_addr || r.be !== mem_bus.mem_be ||
                             r.we !== mem_bus.mem_we || r.wdata !== mem_bus.mem_wdata) begin
                    r.unstable = 1'b1;
                end
                if (!busy) r.busy_bad = 1'b1;
                r.req++;
                if (r.req == dly + 1) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = mrd;
                end
            end
        end
        @(negedge clk);
        r.idle_after = !busy && !done && !mem_bus.mem_req;
    endtask

    task automatic chk_op(input string nm, input res_t r, input exp_t e);
        chk({nm, ".done"}, 32'(r.done_seen), 32'd1);
        chk({nm, ".lat"}, 32'(r.lat), 32'(e.lat));
        chk({nm, ".req"}, 32'(r.req), 32'(e.req));
        chk({nm, ".err"}, 32'(r.err), 32'(e.err));
        chk({nm, ".rdata"}, r.rdata, e.rdata);
        chk({nm, ".idle"}, 32'(r.idle_after), 32'd1);
        if (e.req > 0) begin
            chk({nm, ".addr"}, r.addr, e.addr);
            chk({nm, ".be"}, 32'(r.be), 32'(e.be));
            chk({nm, ".we"}, 32'(r.we), 32'(e.we));
            chk({nm, ".stable"}, 32'(r.unstable), 32'd0);
            chk({nm, ".busy"}, 32'(r.busy_bad), 32'd0);
            if (e.chk_wd) chk({nm, ".wdata"}, r.wdata, e.wdata);
        end
    endtask

    localparam int NV = 14;
    vec_t vec [NV];

    initial begin
        res_t r;
        int   dcount;
        logic mr, mw;
        logic [2:0] f3;
        int   dly, d;

        // Directed vectors: inputs plus hand-derived expectations
        vec[0]  = mk_vec(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0,
                         mk_exp(2, 1, 0, 32'h0, 32'h100, 4'hF, 1, 32'hDEADBEEF, 1));
        vec[1]  = mk_vec(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0,
                         mk_exp(2, 1, 0, 32'hFFFFFF80, 32'h100, 4'h8, 0, 32'h0, 0));
        vec[2]  = mk_vec(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0,
                         mk_exp(2, 1, 0, 32'h00000080, 32'h100, 4'h8, 0, 32'h0, 0));
        vec[3]  = mk_vec(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0,
                         mk_exp(2, 1, 0, 32'h0, 32'h200, 4'hC, 1, 32'hABCDABCD, 1));
        vec[4]  = mk_vec(1, 0, 3'b101, 32'h202, 32'h0, 32'hABCD1234, 0,
                         mk_exp(2, 1, 0, 32'h0000ABCD, 32'h200, 4'hC, 0, 32'h0, 0));
        if (TRAP)
            vec[5] = mk_vec(1, 0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0,
                            mk_exp(1, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0));
        else
            vec[5] = mk_vec(1, 0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0,
                            mk_exp(2, 1, 0, 32'h12345678, 32'h100, 4'hF, 0, 32'h0, 0));
        vec[6]  = mk_vec(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0,
                         mk_exp(1, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0));
        vec[7]  = mk_vec(1, 0, 3'b010, 32'h300, 32'h0, 32'h55555555, 99,
                         mk_exp(5, 4, 1, 32'h0, 32'h300, 4'hF, 0, 32'h0, 0));
        vec[8]  = mk_vec(1, 0, 3'b001, 32'h106, 32'h0, 32'h80017FFF, 2,
                         mk_exp(4, 3, 0, 32'hFFFF8001, 32'h104, 4'hC, 0, 32'h0, 0));
        vec[9]  = mk_vec(0, 1, 3'b000, 32'h001, 32'h123456A5, 32'h0, 0,
                         mk_exp(2, 1, 0, 32'h0, 32'h0, 4'h2, 1, 32'hA5A5A5A5, 1));
        vec[10] = mk_vec(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0,
                         mk_exp(1, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0));
        vec[11] = mk_vec(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0,
                         mk_exp(1, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0));
        vec[12] = mk_vec(1, 0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 3,
                         mk_exp(5, 4, 0, 32'hCAFEF00D, 32'h40, 4'hF, 0, 32'h0, 0));
        vec[13] = mk_vec(1, 0, 3'b000, 32'h102, 32'h0, 32'h117F2233, 1,
                         mk_exp(3, 2, 0, 32'h0000007F, 32'h100, 4'h4, 0, 32'h0, 0));

        rst = 1'b1; valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        func3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst.we", 32'(mem_bus.mem_we), 32'd0);
        chk("rst.addr", mem_bus.mem_addr, 32'd0);
        chk("rst.be", 32'(mem_bus.mem_be), 32'd0);
        chk("rst.wdata", mem_bus.mem_wdata, 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_op(vec[i].mr, vec[i].mw, vec[i].f3, vec[i].a, vec[i].wd, vec[i].mrd, vec[i].dly, r);
            chk_op($sformatf("vec%0d", i), r, vec[i].e);
        end

        // valid with neither MemRead nor MemWrite is a no-op
        @(negedge clk);
        valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("noop.busy", 32'(busy), 32'd0);
        chk("noop.req", 32'(mem_bus.mem_req), 32'd0);
        chk("noop.done", 32'(done), 32'd0);

        // valid held high: ignored in DONE, re-accepted once back in IDLE
        @(negedge clk);
        valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        chk("hold.req1", 32'(mem_bus.mem_req), 32'd1);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h11112222;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("hold.done1", 32'(done), 32'd1);
        chk("hold.rdata1", rdata, 32'h11112222);
        @(negedge clk);
        chk("hold.idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("hold.req2", 32'(mem_bus.mem_req), 32'd1);
        valid = 1'b0; MemRead = 1'b0;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h33334444;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("hold.done2", 32'(done), 32'd1);
        chk("hold.rdata2", rdata, 32'h33334444);
        @(negedge clk);
        chk("hold.end", 32'(busy), 32'd0);

        // Reset while an access is in REQ: access abandoned, no done
        @(negedge clk);
        valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'b010; addr = 32'h80;
        @(negedge clk);
        valid = 1'b0; MemRead = 1'b0;
        chk("mrst.req_before", 32'(mem_bus.mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst.req", 32'(mem_bus.mem_req), 32'd0);
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.done", 32'(done), 32'd0);
        chk("mrst.be", 32'(mem_bus.mem_be), 32'd0);
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("mrst.no_done", 32'(dcount), 32'd0);

        // Random requests against the model
        for (int i = 0; i < 250; i++) begin
            d = int'($urandom_range(0, 19));
            if (d == 0)      begin mr = 1'b1; mw = 1'b1; end
            else if (d < 11) begin mr = 1'b1; mw = 1'b0; end
            else             begin mr = 1'b0; mw = 1'b1; end
            if (mr && !mw) begin
                d  = int'($urandom_range(0, 4));
                f3 = (d < 3) ? 3'(d) : 3'(d + 1);
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            d   = int'($urandom_range(0, 9));
            dly = (d < 5) ? 0 : (d < 8) ? int'($urandom_range(1, 3)) : (d == 8) ? 4 : 7;
            begin
                logic [31:0] ra, rw, rm;
                ra = $urandom; rw = $urandom; rm = $urandom;
                run_op(mr, mw, f3, ra, rw, rm, dly, r);
                chk_op($sformatf("rnd%0d", i), r, model(mr, mw, f3, ra, rw, rm, dly));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit completing the memory operations the control unit starts. It accepts a qualified MemRead/MemWrite request with func3, the effective address and the store data. It drives a single-outstanding req/ack port to data memory with byte enables and lane-aligned write data. It returns sign- or zero-extended load data and a one-cycle done pulse, and holds busy so the core stalls while the access is in flight.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles in REQ without mem_ack before the access is aborted with err.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid  in  1  request strobe; sampled only in IDLE.
- MemRead  in  1  load request, qualified by valid.
- MemWrite  in  1  store request, qualified by valid.
- func3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  effective byte address.
- wdata  in  32  store data (rs2).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load data; valid while done=1.
- err  out  1  valid while done=1; reports an illegal request or a timeout.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  memory read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- Reset: state IDLE. busy, done, err, mem_req, mem_we are 0. rdata, mem_addr, mem_be, mem_wdata are 0.
- IDLE, valid=1:
  - Capture MemRead, MemWrite, func3, addr and wdata.
  - If the request is legal, go to REQ.
  - If the request is illegal, go directly to DONE with err=1. No memory access is made.
- Illegal requests: MemRead=MemWrite=1, an undefined load func3 (011, 110, 111), or a store func3 other than 000/001/010.
- IDLE, valid=1 with MemRead=MemWrite=0: no-op, stays in IDLE.
- Store byte enables and data:
  - sb: be = 4'b0001 << addr[1:0]; the byte is replicated in all four lanes.
  - sh: be = 4'b0011 << {addr[1],1'b0}; the half is replicated in both halves.
  - sw: be = 4'b1111; data is passed unchanged.
- Loads: mem_be follows the same rules as stores and mem_we=0.
- Load extraction:
  - lb/lbu take the byte at lane addr[1:0]; lh/lhu take the half at addr[1]; lw takes the whole word.
  - Signed forms sign-extend to 32 bits; the u forms zero-extend.
- REQ:
  - mem_req=1 and all mem_* outputs are stable until mem_ack.
  - On mem_ack: latch the extracted rdata (stores latch 0), set err=0, go to DONE.
  - The timeout counter clears on entry to REQ. If it reaches TIMEOUT without mem_ack, go to DONE with err=1 and rdata=0.
- DONE: done=1 for exactly one cycle, then return to IDLE. valid is ignored while in DONE.
- Upstream deasserts valid, or presents the next request, in the cycle after done. A valid held high in IDLE is treated as a new request.
- Reset mid-operation: the FSM returns to IDLE on that edge and mem_req drops. No done is emitted and the outstanding access is abandoned.

## Timing
- A request accepted on edge N sets mem_req=1 and busy=1 in cycle N+1.
- When mem_ack=1 in cycle M, done=1 in cycle M+1, and IDLE is reached in cycle M+2.
- Minimum load/store latency is 2 cycles from accept to done, with mem_ack in the first REQ cycle.
- An illegal request gives done=1 in the cycle after accept.
- A mem_ack that arrives in the same cycle the counter reaches TIMEOUT wins; the access completes normally.
- mem_ack outside REQ is ignored.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, is illegal.
  - Such a request goes to DONE with err=1 and makes no memory access.
- LSU_MISALIGN_TRAP_EN undefined:
  - Halfword accesses ignore addr[0] and word accesses ignore addr[1:0].
  - The access proceeds to the containing aligned halfword or word.

## Structure
- The shared package rv32_pkg holds:
  - func3 load/store encodings;
  - the LSU state enum (IDLE, REQ, DONE);
  - the opcode constants already shared with the control unit.
- One sub-module, lsu_align, is purely combinational. It computes mem_be and mem_wdata from func3/addr/wdata, and extended rdata from func3/addr/mem_rdata. The lsu top module holds the FSM, the capture registers and the timeout counter.

## Test plan
- sw at addr 0x100 with wdata 0xDEADBEEF, mem_ack in the first REQ cycle -> mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF, done exactly 2 cycles after accept, err=0.
- lb at addr 0x103, mem_rdata 0x80112233 -> rdata=0xFFFFFF80. The same access as lbu -> rdata=0x00000080.
- sh at addr 0x202 with wdata 0x0000ABCD -> be=1100, mem_wdata=0xABCDABCD. lhu at the same address with mem_rdata 0xABCD1234 -> rdata=0x0000ABCD.
- lw with mem_ack withheld, TIMEOUT=4 -> mem_req high for 4 cycles, then done with err=1 and rdata=0, then IDLE.
- lw at 0x101 -> with the macro: err=1, mem_req never asserted. Without the macro: mem_addr=0x100, normal completion.
- MemRead=MemWrite=1 -> err=1 next cycle. Separately, rst asserted while in REQ -> mem_req, busy, done all 0 after the edge, and no done is ever emitted for that access.
